// File: rtl/updi_mem_access_ctrl.sv
// updi_mem_access_ctrl: single-byte STS/LDS sequencer over a UPDI interface.
// Optional retry-on-error path is enabled by defining UPDI_MEM_CTRL_RETRY_EN.
package updi_pkg;
  typedef enum logic [2:0] {
    UPDI_LDS    = 3'b000,
    UPDI_LD     = 3'b001,
    UPDI_STS    = 3'b010,
    UPDI_ST     = 3'b011,
    UPDI_LDCS   = 3'b100,
    UPDI_REPEAT = 3'b101,
    UPDI_STCS   = 3'b110,
    UPDI_KEY    = 3'b111
  } updi_instruction;
endpackage

module updi_mem_access_ctrl
  import updi_pkg::*;
#(
  parameter int MAX_DATA_SIZE  = 16,
  parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
  parameter int WDOG_CLKS      = 4096,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [15:0]                   req_addr,
  input  logic [7:0]                    req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [7:0]                    resp_rdata,
  output logic [1:0]                    resp_err,
  output updi_instruction               ifc_instruction,
  output logic [1:0]                    ifc_size_a,
  output logic [1:0]                    ifc_size_b,
  output logic [1:0]                    ifc_ptr,
  output logic [3:0]                    ifc_cs_addr,
  output logic                          ifc_sib,
  output logic [1:0]                    ifc_size_c,
  output logic [MAX_DATA_SIZE-1:0][7:0] ifc_data,
  output logic [DATA_ADDR_BITS:0]       ifc_data_len,
  output logic [MAX_DATA_SIZE-1:0]      ifc_wait_ack_after,
  output logic                          ifc_tx_start,
  input  logic                          ifc_tx_ready,
  input  logic                          ifc_tx_done,
  output logic [DATA_ADDR_BITS-1:0]     ifc_rx_n_bytes,
  output logic                          ifc_rx_start,
  input  logic                          ifc_rx_ready,
  input  logic                          ifc_rx_done,
  input  logic                          ifc_rx_timeout,
  input  logic                          ifc_ack_error,
  input  logic [7:0]                    rx_fifo_data,
  input  logic                          rx_fifo_wr_en,
  output logic                          rx_fifo_full,
  output logic                          ifc_rst
);

  localparam int LW   = DATA_ADDR_BITS + 1;
  localparam int WD_W = (WDOG_CLKS > 2) ? $clog2(WDOG_CLKS) : 1;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_ACK  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_WDOG = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TX_START,
    TX_WAIT,
    RX_START,
    RX_WAIT,
    RECOVER,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic            wr_q;
  logic [15:0]     addr_q;
  logic [7:0]      wdata_q;
  logic [7:0]      rx_q;
  logic [1:0]      err_q;
  logic [WD_W-1:0] wdog;
  logic            wdog_hit;
  logic            accept;
  logic            err_set;
  logic [1:0]      err_code;
  logic            retry_ok;

  function automatic logic is_wd(state_t s);
    return s inside {TX_START, TX_WAIT, RX_START, RX_WAIT};
  endfunction

  assign resp_valid   = (state == RESP);
  assign req_ready    = (state == IDLE) && !resp_valid;
  assign accept       = req_valid && req_ready;
  assign ifc_tx_start = (state == TX_START) && ifc_tx_ready;
  assign ifc_rx_start = (state == RX_START) && ifc_rx_ready;
  assign ifc_rst      = (state == RECOVER);
  assign wdog_hit     = (wdog == WD_W'(WDOG_CLKS - 1));

  assign ifc_instruction = wr_q ? UPDI_STS : UPDI_LDS;
  assign ifc_size_a      = 2'b01;
  assign ifc_size_b      = 2'b00;
  assign ifc_ptr         = 2'b00;
  assign ifc_cs_addr     = 4'h0;
  assign ifc_sib         = 1'b0;
  assign ifc_size_c      = 2'b00;
  assign rx_fifo_full    = 1'b0;

`ifdef UPDI_MEM_CTRL_RETRY_EN
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;

  logic [RW-1:0] retry_cnt;

  assign retry_ok = (retry_cnt < RW'(MAX_RETRIES));

  // Retry counter: cleared per request, bumped on each re-attempt.
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (accept) begin
      retry_cnt <= '0;
    end else if (state == RECOVER && retry_ok) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  logic unused_retry;

  assign retry_ok     = 1'b0;
  assign unused_retry = (MAX_RETRIES >= 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; any failure funnels through RECOVER.
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_code  = ERR_OK;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = TX_START;
      end
      TX_START: begin
        if (ifc_tx_ready) begin
          state_nxt = TX_WAIT;
        end else if (wdog_hit) begin
          err_set  = 1'b1;
          err_code = ERR_WDOG;
        end
      end
      TX_WAIT: begin
        if (ifc_ack_error) begin
          err_set  = 1'b1;
          err_code = ERR_ACK;
        end else if (ifc_tx_done) begin
          state_nxt = wr_q ? RESP : RX_START;
        end else if (wdog_hit) begin
          err_set  = 1'b1;
          err_code = ERR_WDOG;
        end
      end
      RX_START: begin
        if (ifc_rx_ready) begin
          state_nxt = RX_WAIT;
        end else if (wdog_hit) begin
          err_set  = 1'b1;
          err_code = ERR_WDOG;
        end
      end
      RX_WAIT: begin
        if (ifc_ack_error) begin
          err_set  = 1'b1;
          err_code = ERR_ACK;
        end else if (ifc_rx_timeout) begin
          err_set  = 1'b1;
          err_code = ERR_TMO;
        end else if (ifc_rx_done) begin
          state_nxt = RESP;
        end else if (wdog_hit) begin
          err_set  = 1'b1;
          err_code = ERR_WDOG;
        end
      end
      RECOVER: begin
        state_nxt = retry_ok ? LOAD : RESP;
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (err_set) state_nxt = RECOVER;
  end

  // Phase watchdog: restarts on entering each bus phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog <= '0;
    end else if (state_nxt != state && is_wd(state_nxt)) begin
      wdog <= '0;
    end else if (is_wd(state)) begin
      wdog <= wdog + 1'b1;
    end
  end

  // Request latch, rx byte capture and error code.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rx_q    <= '0;
      err_q   <= ERR_OK;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rx_q    <= '0;
        err_q   <= ERR_OK;
      end
      if (rx_fifo_wr_en) rx_q <= rx_fifo_data;
      if (err_set) err_q <= err_code;
    end
  end

  // Payload build for the current attempt.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifc_data           <= '0;
      ifc_data_len       <= '0;
      ifc_wait_ack_after <= '0;
      ifc_rx_n_bytes     <= '0;
    end else if (state == LOAD) begin
      ifc_data    <= '0;
      ifc_data[0] <= addr_q[7:0];
      ifc_data[1] <= addr_q[15:8];
      if (wr_q) begin
        ifc_data[2]           <= wdata_q;
        ifc_data_len          <= LW'(3);
        ifc_wait_ack_after    <= '0;
        ifc_wait_ack_after[1] <= 1'b1;
        ifc_wait_ack_after[2] <= 1'b1;
        ifc_rx_n_bytes        <= '0;
      end else begin
        ifc_data_len       <= LW'(2);
        ifc_wait_ack_after <= '0;
        ifc_rx_n_bytes     <= DATA_ADDR_BITS'(1);
      end
    end
  end

  // Response registers, frozen for the whole RESP state.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
    end else if (state_nxt == RESP && state != RESP) begin
      resp_err <= (state == RECOVER) ? err_q : ERR_OK;
      if (wr_q) begin
        resp_rdata <= '0;
      end else begin
        resp_rdata <= rx_fifo_wr_en ? rx_fifo_data : rx_q;
      end
    end
  end

endmodule

// File: doc/updi_mem_access_ctrl.md
UPDI_MEM_ACCESS_CTRL -- requirements
Module: updi_mem_access_ctrl

Interface
REQ-001 SHALL have parameter MAX_DATA_SIZE, default 16, matching the depth of the UPDI interface data buffer.
REQ-002 SHALL have parameter DATA_ADDR_BITS, default $clog2(MAX_DATA_SIZE), the data-index width.
REQ-003 SHALL have parameter WDOG_CLKS, default 4096, the per-phase watchdog limit in clocks.
REQ-004 SHALL have parameter MAX_RETRIES, default 2, the retry attempts per request; used only when the retry macro is defined.
REQ-005 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when both valid and ready are high.
- req_write  in  1  1=STS, 0=LDS.
- req_addr  in  16  target address.
- req_wdata  in  8  write byte.
- resp_valid  out  1  response held until accepted.
- resp_ready  in  1  response consumed.
- resp_rdata  out  8  read byte.
- resp_err  out  2  00 ok, 01 ack error, 10 rx timeout, 11 watchdog.
- ifc_instruction  out  updi_instruction  STS or LDS.
- ifc_size_a  out  2  address size.
- ifc_size_b  out  2  data size.
- ifc_ptr, ifc_cs_addr, ifc_sib, ifc_size_c  out  2/4/1/2  tied 0.
- ifc_data  out  8 x MAX_DATA_SIZE  transmit payload.
- ifc_data_len  out  DATA_ADDR_BITS+1  payload length.
- ifc_wait_ack_after  out  MAX_DATA_SIZE  per-byte ACK wait mask.
- ifc_tx_start  out  1  transmit start.
- ifc_tx_ready  in  1  transmitter ready.
- ifc_tx_done  in  1  transmit complete.
- ifc_rx_n_bytes  out  DATA_ADDR_BITS  bytes to receive.
- ifc_rx_start  out  1  receive start.
- ifc_rx_ready  in  1  receiver ready.
- ifc_rx_done  in  1  receive complete.
- ifc_rx_timeout  in  1  receive timed out.
- ifc_ack_error  in  1  bad ACK received.
- rx_fifo_data  in  8  received byte from the interface output FIFO port.
- rx_fifo_wr_en  in  1  received byte strobe.
- rx_fifo_full  out  1  constant 0.
- ifc_rst  out  1  one-cycle interface recovery reset.

Function
REQ-006 SHALL implement states IDLE, LOAD, TX_START, TX_WAIT, RX_START, RX_WAIT, RECOVER, RESP.
REQ-007 SHALL assert req_ready only in IDLE with resp_valid low; on accept, SHALL latch write, addr and wdata and go to LOAD.
REQ-008 LOAD SHALL drive the payload as follows, then go to TX_START next cycle:
- ifc_data[0] = addr[7:0], ifc_data[1] = addr[15:8].
- ifc_size_a = 01, ifc_size_b = 00.
- Write: ifc_data[2] = wdata, data_len = 3, wait_ack_after bits 1 and 2 set.
- Read: data_len = 2, wait_ack_after = 0, rx_n_bytes = 1.
REQ-009 TX_START SHALL wait for ifc_tx_ready high, pulse ifc_tx_start for exactly 1 cycle, then go to TX_WAIT.
REQ-010 TX_WAIT on ifc_tx_done SHALL go to RESP with err 00 for a write, or to RX_START for a read.
REQ-011 RX_START SHALL wait for ifc_rx_ready, pulse ifc_rx_start for 1 cycle, then go to RX_WAIT.
REQ-012 SHALL capture rx_fifo_data into resp_rdata on rx_fifo_wr_en in any state; the last byte captured wins.
REQ-013 RX_WAIT SHALL handle completion as follows:
- ifc_rx_done goes to RESP with err 00.
- ifc_rx_timeout goes to the error path with err 10.
- If done and timeout are asserted in the same cycle, timeout wins.
REQ-014 ifc_ack_error in TX_WAIT or RX_WAIT SHALL take the error path with err 01, taking priority over done and timeout in the same cycle.
REQ-015 The watchdog counter SHALL clear on entry to TX_START, TX_WAIT, RX_START and RX_WAIT.
- It SHALL count every cycle while in those states.
- Reaching WDOG_CLKS-1 SHALL take the error path with err 11.
REQ-016 The error path without retry SHALL go to RECOVER, then to RESP.
REQ-017 RECOVER SHALL assert ifc_rst for exactly 1 cycle.
REQ-018 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready, then return to IDLE; resp_rdata SHALL be 0 for writes.
REQ-019 ifc_tx_start and ifc_rx_start SHALL never be high in the same cycle.

Reset
REQ-020 On rst, all outputs SHALL reset as follows:
- State goes to IDLE.
- req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 00.
- ifc_tx_start = ifc_rx_start = ifc_rst = 0.
- ifc_data, ifc_data_len and ifc_wait_ack_after = 0.
- Watchdog and retry counters = 0.
REQ-021 rst mid-transaction SHALL abandon the request without a response.

Configuration
REQ-022 Macro UPDI_MEM_CTRL_RETRY_EN defined SHALL change the error path as follows:
- Go to RECOVER, then back to LOAD while retry_cnt < MAX_RETRIES, incrementing retry_cnt.
- After retries are exhausted, go to RESP with the last error code.
- Clear retry_cnt on request accept.
REQ-023 Macro undefined SHALL mean no retry counter exists, and the first error goes RECOVER then RESP.

Verification
REQ-024 Write addr 0x1234 data 0xA5 with ACKs on schedule -> ifc_data = {34,12,A5}, len 3, mask 0b110, one tx_start pulse, resp err 00.
REQ-025 Read addr 0x0F00 with rx byte 0x5C -> len 2, rx_n_bytes 1, rx_start after tx_done, resp_rdata 5C, err 00.
REQ-026 Read with ifc_rx_timeout -> one ifc_rst pulse, err 10; with macro and MAX_RETRIES=2 -> 3 tx_start pulses before the response.
REQ-027 ifc_ack_error during write, and ack_error together with rx_done in the same cycle -> err 01 in both cases.
REQ-028 tx_done never arrives, WDOG_CLKS=16 -> err 11 after 16 cycles in TX_WAIT; resp_ready held low for 10 cycles -> response held stable and req_ready low.
REQ-029 rst asserted in RX_WAIT -> next cycle IDLE, resp_valid 0, req_ready 1.
